// File: rtl/wisc_fetch_pkg.sv
// Shared types and constants for the WISC-F24 instruction-fetch stage.
package wisc_fetch_pkg;
  localparam int WORD_W = 16;
  localparam int OPC_W  = 5;
  localparam logic [OPC_W-1:0]  OPC_HALT = 5'b00000;
  localparam logic [WORD_W-1:0] NOP_WORD = 16'h0800;

  typedef enum logic [1:0] {REQ, WAIT, HALT} fetch_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc_plus2;
  } fetch_rsp_t;

  function automatic logic is_halt(input logic [WORD_W-1:0] w);
    return w[WORD_W-1 -: OPC_W] == OPC_HALT;
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between fetch (master) and memory (slave).
interface fetch_unit_if;
  import wisc_fetch_pkg::*;
  logic [WORD_W-1:0] memAddr;
  logic              memRd;
  logic [WORD_W-1:0] memDataOut;
  logic              memDone;
  logic              memStall;
  logic              memErr;

  modport master (output memAddr, memRd, input memDataOut, memDone, memStall, memErr);
  modport slave  (input memAddr, memRd, output memDataOut, memDone, memStall, memErr);
endinterface

// File: rtl/fetch_out_buf.sv
// Single-entry instruction/pcPlus2 register facing decode: holds on stall, flushes on redirect.
module fetch_out_buf
  import wisc_fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = 16'h0000,
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       flush,
  input  logic       decStall,
  input  fetch_rsp_t din,
  output fetch_rsp_t dout,
  output logic       valid
);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid         <= 1'b0;
      dout.instr    <= NOP_INSTR;
      dout.pc_plus2 <= RESET_PC + 16'd2;
    end else if (flush) begin
      valid      <= 1'b0;
      dout.instr <= NOP_INSTR;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (valid && !decStall) begin
      // consumed with nothing new behind it: show the bubble word
      valid      <= 1'b0;
      dout.instr <= NOP_INSTR;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// WISC-F24 fetch stage: PC, instruction-memory requests, redirect squash and HALT.
// Optional: define FETCH_ALIGN_CHK_EN to trap odd-PC fetches (err + halt).
module fetch_unit
  import wisc_fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = 16'h0000,
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirectPC,
  input  logic              decStall,
  output logic [WORD_W-1:0] instruction,
  output logic [WORD_W-1:0] pcPlus2,
  output logic              instValid,
  output logic              halted,
  output logic              err,
  fetch_unit_if.master      mem
);
  fetch_state_t      state, state_nxt;
  logic [WORD_W-1:0] pc, addr_q;
  logic              squash;
  logic              free, accept, halt_acc, done, misalign, load, flush;
  fetch_rsp_t        rsp, obuf;

  assign free     = !instValid || !decStall;
  assign accept   = instValid && !decStall;
  assign halt_acc = accept && is_halt(instruction) && !redirect;
  assign done     = mem.memRd && mem.memDone && !mem.memStall;
`ifdef FETCH_ALIGN_CHK_EN
  assign misalign = (state == REQ) && !rst && free && !redirect && !halt_acc && pc[0];
`else
  assign misalign = 1'b0;
`endif
  assign load  = done && !squash && !redirect;
  assign flush = (redirect && state != HALT) || halt_acc || misalign;
  assign rsp   = '{instr: mem.memDataOut, pc_plus2: pc + 16'd2};

  always_ff @(posedge clk) begin
    if (rst) state <= REQ;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      REQ:     if (halt_acc || misalign) state_nxt = HALT;
               else if (mem.memRd && !done) state_nxt = WAIT;
      WAIT:    if (done) state_nxt = REQ;
      HALT:    state_nxt = HALT;
      default: state_nxt = REQ;
    endcase
  end

  // A read is only launched into an empty (or draining) output slot, so WAIT
  // always returns with room for the data.
  always_comb begin
    mem.memRd   = 1'b0;
    mem.memAddr = pc;
    halted      = 1'b0;
    unique case (state)
      REQ:     mem.memRd = !rst && free && !redirect && !halt_acc && !misalign;
      WAIT: begin
        mem.memRd   = 1'b1;
        mem.memAddr = addr_q;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

  // pc may move to redirectPC while a squashed read is still outstanding;
  // addr_q keeps the bus address stable until that read completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      addr_q <= RESET_PC;
      squash <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (state != HALT) begin
        if (redirect)            pc <= redirectPC;
        else if (done && !squash) pc <= pc + 16'd2;
      end
      if (state == REQ && mem.memRd) addr_q <= pc;
      if (done)                           squash <= 1'b0;
      else if (state == WAIT && redirect) squash <= 1'b1;
      if ((done && mem.memErr) || misalign) err <= 1'b1;
    end
  end

  fetch_out_buf #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) u_obuf (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .flush    (flush),
    .decStall (decStall),
    .din      (rsp),
    .dout     (obuf),
    .valid    (instValid)
  );

  assign instruction = obuf.instr;
  assign pcPlus2     = obuf.pc_plus2;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small behavioural instruction memory.
module tb_fetch_unit;
  logic        clk, rst, redirect, decStall;
  logic [15:0] redirectPC, instruction, pcPlus2;
  logic        instValid, halted, err;
  int          n_vec, n_bad;

  // memory model knobs
  int          stall_cnt, slow_n;
  logic [15:0] slow_addr, halt_at, err_at;
  logic        halt_en, err_en;

  fetch_unit_if mem_bus();

  fetch_unit dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirectPC(redirectPC),
    .decStall(decStall), .instruction(instruction), .pcPlus2(pcPlus2),
    .instValid(instValid), .halted(halted), .err(err), .mem(mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rom(input logic [15:0] a);
    logic [15:0] t;
    t = (a >> 1) + 16'd1;
    return {4'h4, t[11:0]};
  endfunction

  always_comb begin
    mem_bus.memDone    = mem_bus.memRd &&
                         (stall_cnt >= ((mem_bus.memAddr == slow_addr) ? slow_n : 0));
    mem_bus.memStall   = mem_bus.memRd && !mem_bus.memDone;
    mem_bus.memDataOut = (halt_en && mem_bus.memAddr == halt_at) ? 16'h0000 : rom(mem_bus.memAddr);
    mem_bus.memErr     = err_en && mem_bus.memAddr == err_at && mem_bus.memDone;
  end

  always @(posedge clk) begin
    if (!mem_bus.memRd || mem_bus.memDone) stall_cnt <= 0;
    else                                   stall_cnt <= stall_cnt + 1;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; decStall = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    slow_addr = 16'h1111; slow_n = 0; halt_en = 1'b0; halt_at = 16'h0; err_en = 1'b0; err_at = 16'h0;
    redirectPC = 16'h0;

    // reset values
    rst = 1'b1; redirect = 1'b0; decStall = 1'b0;
    tick(); tick();
    chk("rst_valid", 16'(instValid), 16'd0);
    chk("rst_instr", instruction, 16'h0800);
    chk("rst_pcp2",  pcPlus2, 16'h0002);
    chk("rst_memrd", 16'(mem_bus.memRd), 16'd0);
    chk("rst_halted", 16'(halted), 16'd0);
    chk("rst_err",   16'(err), 16'd0);

    // zero-wait streaming
    rst = 1'b0; #1;
    chk("zw_memrd", 16'(mem_bus.memRd), 16'd1);
    chk("zw_addr0", mem_bus.memAddr, 16'h0000);
    chk("zw_nv",    16'(instValid), 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("zw_valid", 16'(instValid), 16'd1);
      chk("zw_instr", instruction, 16'h4001 + 16'(i));
      chk("zw_pcp2",  pcPlus2, 16'(2 * i + 2));
    end

    // stalled memory on 0x0010
    do_reset();
    slow_addr = 16'h0010; slow_n = 3;
    redirect = 1'b1; redirectPC = 16'h0010; #1;
    tick(); redirect = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      chk("st_memrd", 16'(mem_bus.memRd), 16'd1);
      chk("st_addr",  mem_bus.memAddr, 16'h0010);
      chk("st_nv",    16'(instValid), 16'd0);
      tick();
    end
    chk("st_valid", 16'(instValid), 16'd1);
    chk("st_instr", instruction, 16'h4009);
    chk("st_pcp2",  pcPlus2, 16'h0012);
    slow_addr = 16'h1111;

    // decode stall holds the output slot
    decStall = 1'b1; #1;
    chk("ds_memrd0", 16'(mem_bus.memRd), 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ds_instr", instruction, 16'h4009);
      chk("ds_pcp2",  pcPlus2, 16'h0012);
      chk("ds_valid", 16'(instValid), 16'd1);
      chk("ds_memrd", 16'(mem_bus.memRd), 16'd0);
    end
    decStall = 1'b0; #1;
    chk("ds_resume_rd",   16'(mem_bus.memRd), 16'd1);
    chk("ds_resume_addr", mem_bus.memAddr, 16'h0012);
    tick();
    chk("ds_next_instr", instruction, 16'h400A);
    chk("ds_next_pcp2",  pcPlus2, 16'h0014);

    // redirect while a read on 0x0008 is outstanding
    do_reset();
    slow_addr = 16'h0008; slow_n = 20;
    redirect = 1'b1; redirectPC = 16'h0008; #1;
    tick(); redirect = 1'b0; #1;
    chk("sq_addr8", mem_bus.memAddr, 16'h0008);
    tick();
    redirect = 1'b1; redirectPC = 16'h0100; #1;
    chk("sq_rd_hold", 16'(mem_bus.memRd), 16'd1);
    tick(); redirect = 1'b0; slow_n = 0; #1;
    chk("sq_addr_stable", mem_bus.memAddr, 16'h0008);
    chk("sq_done_seen", 16'(mem_bus.memDone), 16'd1);
    tick();
    chk("sq_dropped", 16'(instValid), 16'd0);
    chk("sq_newaddr", mem_bus.memAddr, 16'h0100);
    tick();
    chk("sq_valid", 16'(instValid), 16'd1);
    chk("sq_instr", instruction, 16'h4081);
    chk("sq_pcp2",  pcPlus2, 16'h0102);
    slow_addr = 16'h1111;

    // HALT at PC 6
    halt_en = 1'b1; halt_at = 16'h0006;
    do_reset();
    repeat (4) tick();
    chk("h_instr", instruction, 16'h0000);
    chk("h_accept_rd", 16'(mem_bus.memRd), 16'd0);
    tick();
    chk("h_halted", 16'(halted), 16'd1);
    chk("h_valid",  16'(instValid), 16'd0);
    redirect = 1'b1; redirectPC = 16'h0040; #1;
    chk("h_rd_redir", 16'(mem_bus.memRd), 16'd0);
    tick(); redirect = 1'b0; #1;
    for (int i = 0; i < 2; i++) begin
      chk("h_stay", 16'(halted), 16'd1);
      chk("h_memrd", 16'(mem_bus.memRd), 16'd0);
      chk("h_nv", 16'(instValid), 16'd0);
      tick();
    end
    do_reset();
    chk("h_rst_halted", 16'(halted), 16'd0);
    chk("h_rst_rd",   16'(mem_bus.memRd), 16'd1);
    chk("h_rst_addr", mem_bus.memAddr, 16'h0000);

    // redirect in the HALT-accept cycle wins; target fetch returns memErr
    err_en = 1'b1; err_at = 16'h0020;
    do_reset();
    repeat (4) tick();
    chk("hr_instr", instruction, 16'h0000);
    redirect = 1'b1; redirectPC = 16'h0020; #1;
    tick(); redirect = 1'b0; #1;
    chk("hr_halted", 16'(halted), 16'd0);
    chk("hr_nv",     16'(instValid), 16'd0);
    chk("hr_addr",   mem_bus.memAddr, 16'h0020);
    chk("hr_err0",   16'(err), 16'd0);
    tick();
    chk("er_valid", 16'(instValid), 16'd1);
    chk("er_instr", instruction, 16'h4011);
    chk("er_pcp2",  pcPlus2, 16'h0022);
    chk("er_err",   16'(err), 16'd1);
    repeat (3) tick();
    chk("er_sticky", 16'(err), 16'd1);
    halt_en = 1'b0; err_en = 1'b0;
    do_reset();
    chk("er_rst", 16'(err), 16'd0);

    // PC wrap
    redirect = 1'b1; redirectPC = 16'hFFFE; #1;
    tick(); redirect = 1'b0; #1;
    chk("wr_addr", mem_bus.memAddr, 16'hFFFE);
    tick();
    chk("wr_instr", instruction, 16'h4000);
    chk("wr_pcp2",  pcPlus2, 16'h0000);
    chk("wr_next",  mem_bus.memAddr, 16'h0000);

    // odd PC
    do_reset();
    redirect = 1'b1; redirectPC = 16'h0031; #1;
    tick(); redirect = 1'b0; #1;
`ifdef FETCH_ALIGN_CHK_EN
    chk("al_rd", 16'(mem_bus.memRd), 16'd0);
    tick();
    chk("al_err",    16'(err), 16'd1);
    chk("al_halted", 16'(halted), 16'd1);
    chk("al_rd2",    16'(mem_bus.memRd), 16'd0);
`else
    chk("al_rd",   16'(mem_bus.memRd), 16'd1);
    chk("al_addr", mem_bus.memAddr, 16'h0031);
    tick();
    chk("al_instr", instruction, 16'h4019);
    chk("al_err",   16'(err), 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
